// File: rtl/ifu_fetch.sv
// Instruction fetch unit: in-order request issue, response buffering and redirect flush.
// Optional macro IFU_MISALIGN_TRAP_EN enables the misaligned-redirect HALT trap.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_o_mem_req_valid,
  output logic [31:0] ifu_o_mem_req_addr,
  input  logic        ifu_i_mem_req_ready,
  input  logic        ifu_i_mem_rsp_valid,
  input  logic [31:0] ifu_i_mem_rsp_data,
  input  logic        ifu_i_redirect,
  input  logic [31:0] ifu_i_redirect_pc,
  output logic        ifu_o_valid,
  output logic [31:0] ifu_o_inst,
  output logic [31:0] ifu_o_pc,
  input  logic        ifu_i_ready,
  output logic        ifu_o_misaligned
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int unsigned PTR_W    = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t           state;
  logic [31:0]      req_pc;
  logic [31:0]      rsp_pc;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] occ;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [31:0]      buf_inst [BUF_DEPTH];
  logic [31:0]      buf_pc   [BUF_DEPTH];

  logic [31:0]      redir_pc;
  logic             redir_bad;
  logic             req_fire;
  logic             rsp_keep;
  logic             pop;
  logic [CNT_W-1:0] out_nxt;

`ifdef IFU_MISALIGN_TRAP_EN
  assign redir_pc  = ifu_i_redirect_pc;
  assign redir_bad = |ifu_i_redirect_pc[1:0];
`else
  assign redir_pc  = ifu_i_redirect_pc & ~32'h3;
  assign redir_bad = 1'b0;
`endif

  // Outstanding plus buffered entries never exceed the buffer, so every response has a slot.
  assign ifu_o_mem_req_valid = (state == FETCH) && !ifu_i_redirect &&
                               (({1'b0, out_cnt} + {1'b0, occ}) < (CNT_W+1)'(BUF_DEPTH));
  assign ifu_o_mem_req_addr  = req_pc;

  assign req_fire = ifu_o_mem_req_valid & ifu_i_mem_req_ready;
  assign rsp_keep = ifu_i_mem_rsp_valid & ~ifu_i_redirect & (drop_cnt == '0);
  assign pop      = ifu_o_valid & ifu_i_ready;
  assign out_nxt  = out_cnt + CNT_W'(req_fire) - CNT_W'(ifu_i_mem_rsp_valid);

  assign ifu_o_valid = (occ != '0);
  assign ifu_o_inst  = ifu_o_valid ? buf_inst[rd_ptr] : NOP_INST;
  assign ifu_o_pc    = ifu_o_valid ? buf_pc[rd_ptr]   : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_pc   <= RESET_PC;
      rsp_pc   <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
      occ      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (ifu_i_redirect) begin
      // A response landing in this cycle is already retired in out_nxt, so it is not re-counted as a drop.
      state    <= redir_bad ? HALT : FETCH;
      req_pc   <= redir_pc;
      rsp_pc   <= redir_pc;
      out_cnt  <= out_nxt;
      drop_cnt <= out_nxt;
      occ      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (state == IDLE) state <= FETCH;
      if (req_fire) req_pc <= req_pc + 32'd4;
      out_cnt <= out_nxt;
      if (ifu_i_mem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      if (rsp_keep) begin
        wr_ptr <= wr_ptr + 1'b1;
        rsp_pc <= rsp_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + CNT_W'(rsp_keep) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      buf_inst[wr_ptr] <= ifu_i_mem_rsp_data;
      buf_pc[wr_ptr]   <= rsp_pc;
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  logic mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 mis_q <= 1'b0;
    else if (ifu_i_redirect) mis_q <= redir_bad;
  end

  assign ifu_o_misaligned = mis_q;
`else
  assign ifu_o_misaligned = 1'b0;
`endif

endmodule
